frame_reader: RTL and testbench

//  Read-side sequencer for the frame buffer block RAM. On a start pulse it walks
//  LEN bytes from a base address through the RAM read port. Each byte is presented
//  to the transmitter on a valid/ready byte stream, with tx_last on the final byte.

---
 rtl/frame_reader_pkg.sv | 21 ++
 rtl/frame_reader_if.sv | 38 +++
 rtl/frame_reader.sv | 157 +++++++++++++++
 tb/tb_frame_reader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_reader_pkg.sv
// Shared definitions for the frame buffer read sequencer: default widths and
// the sequencer state encoding.
// Optional feature macro: FRAME_READER_FCS_EN adds the XOR check-byte state.
package frame_reader_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_LEN_W  = 9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SEND  = 3'd3,
`ifdef FRAME_READER_FCS_EN
        S_FCS   = 3'd4,
`endif
        S_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/frame_reader_if.sv
// Bundle of the frame reader's command, RAM read-port and byte-stream signals.
// The master side issues commands, supplies RAM data and drives tx_ready; the
// slave side is the frame reader itself.
// Optional feature macro: FRAME_READER_FCS_EN (no interface change).
interface frame_reader_if
    import frame_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
);
    // command side
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len;
    logic              abort;
    logic              busy;
    logic              done;
    // frame buffer RAM read port
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    // byte stream to the transmitter
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_last;

    modport master (
        output start, base_addr, len, abort, mem_data, tx_ready,
        input  busy, done, mem_addr, tx_data, tx_valid, tx_last
    );

    modport slave (
        input  start, base_addr, len, abort, mem_data, tx_ready,
        output busy, done, mem_addr, tx_data, tx_valid, tx_last
    );

endinterface

// File: rtl/frame_reader.sv
// Read-side sequencer for the frame buffer RAM. A start pulse walks len bytes
// from base_addr (wrapping past the top of the RAM) and presents each byte on a
// valid/ready stream with tx_last on the final byte.
// Optional feature macro: FRAME_READER_FCS_EN appends an XOR-of-all-bytes check
// byte after the last data byte (not sent for an empty frame).
module frame_reader
    import frame_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
)(
    input  logic          clk,
    input  logic          rst_n,
    frame_reader_if.slave fr
);

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_valid_q;
    logic              tx_last_q;
`ifdef FRAME_READER_FCS_EN
    logic [DATA_W-1:0] fcs_q;
`endif

    // Byte index after the one currently on the stream, and where it lives.
    logic [LEN_W-1:0]  idx_inc_d;
    logic [ADDR_W-1:0] addr_next_d;
    logic              more_d;
    logic              last_data_d;

    assign idx_inc_d   = idx_q + 1'b1;
    assign addr_next_d = base_q + ADDR_W'(idx_inc_d);
    assign more_d      = (idx_inc_d < len_q);
    assign last_data_d = (idx_inc_d == len_q);

    assign fr.busy     = busy_q;
    assign fr.done     = done_q;
    assign fr.mem_addr = mem_addr_q;
    assign fr.tx_data  = tx_data_q;
    assign fr.tx_valid = tx_valid_q;
    assign fr.tx_last  = tx_last_q;

    // Sequencer FSM with registered outputs. mem_addr is loaded one state ahead
    // of FETCH so the RAM latches it at the FETCH edge and its data is ready to
    // be captured in LOAD, giving three cycles per byte with tx_ready high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_addr_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
`ifdef FRAME_READER_FCS_EN
            fcs_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (fr.abort && (state_q != S_IDLE)) begin
                // Abort beats everything, but a byte accepted this same edge
                // still counts as sent.
                if ((state_q == S_SEND) && fr.tx_ready) begin
                    idx_q <= idx_inc_d;
                end
                state_q    <= S_IDLE;
                busy_q     <= 1'b0;
                tx_valid_q <= 1'b0;
                tx_last_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (fr.start && !fr.abort) begin
                            base_q <= fr.base_addr;
                            len_q  <= fr.len;
                            idx_q  <= '0;
                            busy_q <= 1'b1;
`ifdef FRAME_READER_FCS_EN
                            fcs_q  <= '0;
`endif
                            if (fr.len == '0) begin
                                state_q <= S_DONE;
                            end else begin
                                mem_addr_q <= fr.base_addr;
                                state_q    <= S_FETCH;
                            end
                        end
                    end
                    S_FETCH: begin
                        state_q <= S_LOAD;
                    end
                    S_LOAD: begin
                        tx_data_q  <= fr.mem_data;
                        tx_valid_q <= 1'b1;
`ifdef FRAME_READER_FCS_EN
                        fcs_q      <= fcs_q ^ fr.mem_data;
                        tx_last_q  <= 1'b0;
`else
                        tx_last_q  <= last_data_d;
`endif
                        state_q    <= S_SEND;
                    end
                    S_SEND: begin
                        if (fr.tx_ready) begin
                            tx_valid_q <= 1'b0;
                            tx_last_q  <= 1'b0;
                            idx_q      <= idx_inc_d;
                            if (more_d) begin
                                mem_addr_q <= addr_next_d;
                                state_q    <= S_FETCH;
                            end else begin
`ifdef FRAME_READER_FCS_EN
                                state_q <= S_FCS;
`else
                                state_q <= S_DONE;
`endif
                            end
                        end
                    end
`ifdef FRAME_READER_FCS_EN
                    S_FCS: begin
                        // First cycle loads the check byte; then hold until taken.
                        if (!tx_valid_q) begin
                            tx_data_q  <= fcs_q;
                            tx_valid_q <= 1'b1;
                            tx_last_q  <= 1'b1;
                        end else if (fr.tx_ready) begin
                            tx_valid_q <= 1'b0;
                            tx_last_q  <= 1'b0;
                            state_q    <= S_DONE;
                        end
                    end
`endif
                    S_DONE: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_reader.sv
// Self-checking bench for frame_reader: frame buffer RAM model with a write
// port, directed scenarios and randomized frames checked against a simple
// list-of-bytes reference built from a mirror of the RAM contents.
module tb_frame_reader;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int LW    = 9;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    frame_reader_if #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) fr ();

    frame_reader #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fr    (fr.slave)
    );

    // Frame buffer RAM: synchronous write port, registered read port.
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] ram    [DEPTH];
    logic [DW-1:0] mirror [DEPTH];

    always @(posedge clk) begin
        if (we) ram[waddr] <= wdata;
        fr.mem_data <= ram[fr.mem_addr];
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"},     32'(fr.busy),     32'd0);
        check({tag, "_done"},     32'(fr.done),     32'd0);
        check({tag, "_tx_valid"}, 32'(fr.tx_valid), 32'd0);
        check({tag, "_tx_last"},  32'(fr.tx_last),  32'd0);
        check({tag, "_tx_data"},  32'(fr.tx_data),  32'd0);
        check({tag, "_mem_addr"}, 32'(fr.mem_addr), 32'd0);
    endtask

    task automatic ram_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        mirror[a] = d;
    endtask

    // One frame with random/forced backpressure; every accepted byte is compared
    // with the expected list, plus latency, done timing and hold stability.
    task automatic run_frame(input logic [AW-1:0] base, input logic [LW-1:0] len,
                             input int stall_pct, input int stall_idx, input bit noise);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] acc;
        logic [AW-1:0] a;
        logic          pv, pr, pl;
        logic [DW-1:0] pd;
        logic [AW-1:0] pa;
        int k, got, done_k, first_k, last_k, stall_cnt, budget;
        acc = '0;
        for (int i = 0; i < int'(len); i++) begin
            a = base + AW'(i);
            exp_q.push_back(mirror[a]);
            acc ^= mirror[a];
        end
`ifdef FRAME_READER_FCS_EN
        if (len != '0) exp_q.push_back(acc);
`endif
        budget = 40 + 40 * int'(len);
        k = 0; got = 0; done_k = -1; first_k = -1; last_k = -1; stall_cnt = 0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pa = '0;
        @(negedge clk);
        fr.start = 1'b1; fr.base_addr = base; fr.len = len;
        fr.tx_ready = ($urandom_range(99) >= stall_pct);
        while (done_k < 0 && k < budget) begin
            @(negedge clk);
            k++;
            fr.start = 1'b0;
            if (pv && !pr) begin
                check("hold_valid", 32'(fr.tx_valid), 32'd1);
                check("hold_data",  32'(fr.tx_data),  32'(pd));
                check("hold_last",  32'(fr.tx_last),  32'(pl));
                check("hold_addr",  32'(fr.mem_addr), 32'(pa));
            end
            if (k == 1) check("busy_after_start", 32'(fr.busy), 32'd1);
            if (fr.tx_valid && first_k < 0) first_k = k;
            if (fr.done) begin
                done_k = k;
                check("busy_at_done", 32'(fr.busy), 32'd0);
            end
            if (fr.tx_valid && got == stall_idx && stall_cnt < 5) begin
                fr.tx_ready = 1'b0;
                stall_cnt++;
            end else begin
                fr.tx_ready = ($urandom_range(99) >= stall_pct);
            end
            if (fr.tx_valid && fr.tx_ready) begin
                if (got < exp_q.size()) begin
                    check("byte", 32'(fr.tx_data), 32'(exp_q[got]));
                    check("last", 32'(fr.tx_last), 32'(got == exp_q.size() - 1));
                    if (got < int'(len))
                        check("addr", 32'(fr.mem_addr), 32'(AW'(base + AW'(got))));
                    if (stall_pct == 0 && stall_idx < 0 && got > 0 && got < int'(len))
                        check("byte_gap", 32'(k - last_k), 32'd3);
                end else begin
                    check("extra_byte", 32'(got), 32'(exp_q.size()));
                end
                got++;
                last_k = k;
            end
            if (noise && fr.busy && !fr.done) begin
                fr.start     = 1'($urandom_range(1));
                fr.base_addr = AW'($urandom);
                fr.len       = LW'($urandom);
            end
            pv = fr.tx_valid; pr = fr.tx_ready; pd = fr.tx_data;
            pl = fr.tx_last;  pa = fr.mem_addr;
        end
        fr.start = 1'b0;
        fr.tx_ready = 1'b1;
        check("done_seen",  32'(done_k >= 0), 32'd1);
        check("byte_count", 32'(got), 32'(exp_q.size()));
        if (len != '0) check("first_valid_latency", 32'(first_k), 32'd3);
        if (done_k >= 0)
            check("done_timing", 32'(done_k), 32'((len == '0) ? 2 : last_k + 2));
        repeat (2) begin
            @(negedge clk);
            check("after_valid", 32'(fr.tx_valid), 32'd0);
            check("after_done",  32'(fr.done),     32'd0);
            check("after_busy",  32'(fr.busy),     32'd0);
        end
    endtask

    // Abort while the second of four bytes is presented, with or without a
    // simultaneous accept.
    task automatic abort_test(input bit ready_at_abort);
        int  got;
        bit  reached;
        bit  saw_done;
        got = 0; reached = 1'b0; saw_done = 1'b0;
        @(negedge clk);
        fr.start = 1'b1; fr.base_addr = 8'h40; fr.len = 9'd4; fr.tx_ready = 1'b1;
        for (int k = 0; k < 30 && !reached; k++) begin
            @(negedge clk);
            fr.start = 1'b0;
            if (fr.tx_valid) begin
                if (got == 0) begin
                    fr.tx_ready = 1'b1;
                    got++;
                end else begin
                    check("abort_byte2", 32'(fr.tx_data), 32'(mirror[8'h41]));
                    fr.tx_ready = ready_at_abort;
                    fr.abort = 1'b1;
                    reached = 1'b1;
                end
            end
        end
        check("abort_reached", 32'(reached), 32'd1);
        @(negedge clk);
        fr.abort = 1'b0;
        fr.tx_ready = 1'b1;
        if (fr.done) saw_done = 1'b1;
        check("abort_valid", 32'(fr.tx_valid), 32'd0);
        check("abort_last",  32'(fr.tx_last),  32'd0);
        check("abort_busy",  32'(fr.busy),     32'd0);
        repeat (5) begin
            @(negedge clk);
            if (fr.done) saw_done = 1'b1;
            check("abort_quiet", 32'(fr.tx_valid), 32'd0);
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        fr.start = 1'b0; fr.base_addr = '0; fr.len = '0;
        fr.abort = 1'b0; fr.tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) ram_write(AW'(i), DW'($urandom));
        ram_write(8'h10, 8'h01);
        ram_write(8'h11, 8'h02);
        ram_write(8'h12, 8'h04);
        @(negedge clk);
        we = 1'b0;

        // Basic frame, wrap past top of RAM, backpressure on byte 2.
        run_frame(8'h10, 9'd3, 0, -1, 1'b0);
        run_frame(8'hFE, 9'd4, 0, -1, 1'b0);
        run_frame(8'h20, 9'd6, 0, 1, 1'b0);

        // Empty frame, with a start attempted while busy.
        @(negedge clk);
        fr.start = 1'b1; fr.base_addr = 8'h33; fr.len = '0;
        @(negedge clk);
        check("len0_busy",  32'(fr.busy),     32'd1);
        check("len0_valid", 32'(fr.tx_valid), 32'd0);
        fr.start = 1'b1; fr.len = 9'd3;
        @(negedge clk);
        fr.start = 1'b0;
        check("len0_done",      32'(fr.done), 32'd1);
        check("len0_busy_done", 32'(fr.busy), 32'd0);
        @(negedge clk);
        check("len0_done_once",   32'(fr.done), 32'd0);
        check("len0_start_ignored", 32'(fr.busy), 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("len0_no_valid", 32'(fr.tx_valid), 32'd0);
        end
        run_frame(8'h00, '0, 0, -1, 1'b1);

        // Abort together with start in IDLE: nothing starts.
        @(negedge clk);
        fr.start = 1'b1; fr.abort = 1'b1; fr.base_addr = 8'h00; fr.len = 9'd3;
        @(negedge clk);
        fr.start = 1'b0; fr.abort = 1'b0;
        check("abort_start_busy", 32'(fr.busy), 32'd0);
        @(negedge clk);
        check("abort_start_busy2",  32'(fr.busy),     32'd0);
        check("abort_start_valid",  32'(fr.tx_valid), 32'd0);

        abort_test(1'b0);
        run_frame(8'h40, 9'd4, 0, -1, 1'b0);
        abort_test(1'b1);
        run_frame(8'h40, 9'd4, 30, -1, 1'b0);

        // Reset in the middle of a frame.
        @(negedge clk);
        fr.start = 1'b1; fr.base_addr = 8'h80; fr.len = 9'd5; fr.tx_ready = 1'b0;
        @(negedge clk);
        fr.start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_valid", 32'(fr.tx_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("midreset");
        rst_n = 1'b1;
        fr.tx_ready = 1'b1;
        run_frame(8'h80, 9'd5, 0, -1, 1'b0);

        // Randomized frames with fresh RAM contents and random backpressure.
        for (int f = 0; f < 12; f++) begin
            int sp;
            logic [LW-1:0] ln;
            repeat (8) ram_write(AW'($urandom), DW'($urandom));
            @(negedge clk);
            we = 1'b0;
            sp = (f % 3) * 30;
            ln = (f == 5) ? 9'd300 : LW'($urandom_range(0, 24));
            run_frame(AW'($urandom), ln, sp, -1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
